// File: rtl/tg_edge_delay_monitor.sv
// tg_edge_delay_monitor
//   Multi-channel trigger-to-response delay checker. A rising trigger opens a
//   window of [dly_min, dly_max] cycles; the response must rise inside it.
//   Each channel keeps saturating pass/fail counters, sticky failure causes
//   and one-cycle result pulses.
//
// Ports
//   clk          clock, all logic on posedge
//   C_purstb     synchronous active-low reset
//   clr          synchronous clear of counters and sticky flags (FSMs untouched)
//   ch_en        per-channel enable
//   trig, resp   per-channel trigger / response
//   dly_min/max  per-channel window bounds, channel i at [i*DW +: DW]
//   busy         channel window open
//   pass_pulse   one-cycle pass pulse
//   fail_pulse   one-cycle fail pulse
//   pass_cnt     per-channel pass count, channel i at [i*CW +: CW]
//   fail_cnt     per-channel fail count, same packing
//   err_early    sticky: response rose before dly_min
//   err_timeout  sticky: no response by dly_max
//   err_retrig   sticky: trigger rose while the window was open
//   err_cfg      sticky: dly_min > dly_max at trigger
//
// Per-channel FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no window open, waiting for an enabled trigger rise
//   ST_WAIT | window open, elapsed_q holds the cycle index of the next edge

module tg_edge_delay_monitor #(
  parameter int NCH = 4,
  parameter int DW  = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              C_purstb,
  input  logic              clr,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH-1:0]    resp,
  input  logic [NCH*DW-1:0] dly_min,
  input  logic [NCH*DW-1:0] dly_max,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    pass_pulse,
  output logic [NCH-1:0]    fail_pulse,
  output logic [NCH*CW-1:0] pass_cnt,
  output logic [NCH*CW-1:0] fail_cnt,
  output logic [NCH-1:0]    err_early,
  output logic [NCH-1:0]    err_timeout,
  output logic [NCH-1:0]    err_retrig,
  output logic [NCH-1:0]    err_cfg
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_q   [NCH];
  state_t        state_d   [NCH];
  logic [DW-1:0] elapsed_q [NCH];
  logic [DW-1:0] elapsed_d [NCH];
  logic [DW-1:0] dmin_q    [NCH];
  logic [DW-1:0] dmin_d    [NCH];
  logic [DW-1:0] dmax_q    [NCH];
  logic [DW-1:0] dmax_d    [NCH];
  logic [CW-1:0] pass_cnt_q[NCH];
  logic [CW-1:0] pass_cnt_d[NCH];
  logic [CW-1:0] fail_cnt_q[NCH];
  logic [CW-1:0] fail_cnt_d[NCH];

  logic [NCH-1:0] trig_q, trig_d;
  logic [NCH-1:0] resp_q, resp_d;
  logic [NCH-1:0] pass_pulse_q, pass_pulse_d;
  logic [NCH-1:0] fail_pulse_q, fail_pulse_d;
  logic [NCH-1:0] err_early_q, err_early_d;
  logic [NCH-1:0] err_timeout_q, err_timeout_d;
  logic [NCH-1:0] err_retrig_q, err_retrig_d;
  logic [NCH-1:0] err_cfg_q, err_cfg_d;

  // Up to three failures can land in one cycle (old-window result, retrigger,
  // and a bad or zero-length new window), hence the 2-bit increment.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  always_comb begin
    trig_d        = trig;
    resp_d        = resp;
    pass_pulse_d  = '0;
    fail_pulse_d  = '0;
    err_early_d   = '0;
    err_timeout_d = '0;
    err_retrig_d  = '0;
    err_cfg_d     = '0;
    for (int i = 0; i < NCH; i++) begin : g_ch
      logic          trig_rise, resp_rise, pass_ev;
      logic          set_early, set_timeout, set_retrig, set_cfg;
      logic [1:0]    fail_n;
      logic [DW-1:0] cmin, cmax;

      trig_rise   = trig[i] & ~trig_q[i];
      resp_rise   = resp[i] & ~resp_q[i];
      cmin        = dly_min[i*DW +: DW];
      cmax        = dly_max[i*DW +: DW];
      state_d[i]   = state_q[i];
      elapsed_d[i] = elapsed_q[i];
      dmin_d[i]    = dmin_q[i];
      dmax_d[i]    = dmax_q[i];
      pass_ev     = 1'b0;
      fail_n      = 2'd0;
      set_early   = 1'b0;
      set_timeout = 1'b0;
      set_retrig  = 1'b0;
      set_cfg     = 1'b0;

      if (!ch_en[i]) begin
        state_d[i] = ST_IDLE;
      end else begin
        // Resolve the open window first; a retrigger is handled afterwards.
        if (state_q[i] == ST_WAIT) begin
          if (resp_rise) begin
            state_d[i] = ST_IDLE;
            if (elapsed_q[i] < dmin_q[i]) begin
              set_early = 1'b1;
              fail_n    = fail_n + 2'd1;
            end else begin
              pass_ev = 1'b1;
            end
          end else if (elapsed_q[i] == dmax_q[i]) begin
            state_d[i]  = ST_IDLE;
            set_timeout = 1'b1;
            fail_n      = fail_n + 2'd1;
          end else begin
            elapsed_d[i] = elapsed_q[i] + DW'(1);
          end
          if (trig_rise) begin
            set_retrig = 1'b1;
            fail_n     = fail_n + 2'd1;
          end
        end

        // New window: this edge is elapsed 0. A response on a retrigger edge
        // already belongs to the old window and is not reused.
        if (trig_rise) begin
          if (cmin > cmax) begin
            state_d[i] = ST_IDLE;
            set_cfg    = 1'b1;
            fail_n     = fail_n + 2'd1;
          end else begin
            dmin_d[i] = cmin;
            dmax_d[i] = cmax;
            if (resp_rise && (state_q[i] == ST_IDLE)) begin
              state_d[i] = ST_IDLE;
              if (cmin != '0) begin
                set_early = 1'b1;
                fail_n    = fail_n + 2'd1;
              end else begin
                pass_ev = 1'b1;
              end
            end else if (cmax == '0) begin
              state_d[i]  = ST_IDLE;
              set_timeout = 1'b1;
              fail_n      = fail_n + 2'd1;
            end else begin
              state_d[i]   = ST_WAIT;
              elapsed_d[i] = DW'(1);
            end
          end
        end
      end

      pass_pulse_d[i]  = pass_ev;
      fail_pulse_d[i]  = (fail_n != 2'd0);
      pass_cnt_d[i]    = clr ? '0 : sat_add(pass_cnt_q[i], {1'b0, pass_ev});
      fail_cnt_d[i]    = clr ? '0 : sat_add(fail_cnt_q[i], fail_n);
      // A cause raised in the clearing cycle survives the clear.
      err_early_d[i]   = (err_early_q[i]   & ~clr) | set_early;
      err_timeout_d[i] = (err_timeout_q[i] & ~clr) | set_timeout;
      err_retrig_d[i]  = (err_retrig_q[i]  & ~clr) | set_retrig;
      err_cfg_d[i]     = (err_cfg_q[i]     & ~clr) | set_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (!C_purstb) begin
      trig_q        <= '0;
      resp_q        <= '0;
      pass_pulse_q  <= '0;
      fail_pulse_q  <= '0;
      err_early_q   <= '0;
      err_timeout_q <= '0;
      err_retrig_q  <= '0;
      err_cfg_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]    <= ST_IDLE;
        elapsed_q[i]  <= '0;
        dmin_q[i]     <= '0;
        dmax_q[i]     <= '0;
        pass_cnt_q[i] <= '0;
        fail_cnt_q[i] <= '0;
      end
    end else begin
      trig_q        <= trig_d;
      resp_q        <= resp_d;
      pass_pulse_q  <= pass_pulse_d;
      fail_pulse_q  <= fail_pulse_d;
      err_early_q   <= err_early_d;
      err_timeout_q <= err_timeout_d;
      err_retrig_q  <= err_retrig_d;
      err_cfg_q     <= err_cfg_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]    <= state_d[i];
        elapsed_q[i]  <= elapsed_d[i];
        dmin_q[i]     <= dmin_d[i];
        dmax_q[i]     <= dmax_d[i];
        pass_cnt_q[i] <= pass_cnt_d[i];
        fail_cnt_q[i] <= fail_cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      busy[i]               = (state_q[i] == ST_WAIT);
      pass_cnt[i*CW +: CW]  = pass_cnt_q[i];
      fail_cnt[i*CW +: CW]  = fail_cnt_q[i];
    end
  end

  assign pass_pulse  = pass_pulse_q;
  assign fail_pulse  = fail_pulse_q;
  assign err_early   = err_early_q;
  assign err_timeout = err_timeout_q;
  assign err_retrig  = err_retrig_q;
  assign err_cfg     = err_cfg_q;

endmodule

// File: tb/tb_tg_edge_delay_monitor.sv
// Bench for tg_edge_delay_monitor: a default instance (CW=16) and a narrow
// instance (CW=2) share all stimulus and are checked every cycle against a
// cycle-indexed reference model, plus directed table and corner sequences.

module tb_tg_edge_delay_monitor;

  logic        clk = 1'b0;
  logic        C_purstb, clr;
  logic [3:0]  ch_en, trig, resp;
  logic [15:0] dly_min, dly_max;

  logic [3:0]  busy, pass_pulse, fail_pulse, err_early, err_timeout, err_retrig, err_cfg;
  logic [63:0] pass_cnt, fail_cnt;
  logic [3:0]  busy_s, pass_pulse_s, fail_pulse_s, err_early_s, err_timeout_s, err_retrig_s, err_cfg_s;
  logic [7:0]  pass_cnt_s, fail_cnt_s;

  always #5 clk = ~clk;

  tg_edge_delay_monitor #(.NCH(4), .DW(4), .CW(16)) dut (
    .clk(clk), .C_purstb(C_purstb), .clr(clr), .ch_en(ch_en), .trig(trig), .resp(resp),
    .dly_min(dly_min), .dly_max(dly_max), .busy(busy), .pass_pulse(pass_pulse),
    .fail_pulse(fail_pulse), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_early(err_early), .err_timeout(err_timeout), .err_retrig(err_retrig), .err_cfg(err_cfg));

  tg_edge_delay_monitor #(.NCH(4), .DW(4), .CW(2)) dut_s (
    .clk(clk), .C_purstb(C_purstb), .clr(clr), .ch_en(ch_en), .trig(trig), .resp(resp),
    .dly_min(dly_min), .dly_max(dly_max), .busy(busy_s), .pass_pulse(pass_pulse_s),
    .fail_pulse(fail_pulse_s), .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s),
    .err_early(err_early_s), .err_timeout(err_timeout_s), .err_retrig(err_retrig_s), .err_cfg(err_cfg_s));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: windows remembered by the cycle number of their trigger.
  bit       m_pt[4], m_pr[4], m_open[4];
  int       m_start[4], m_wmin[4], m_wmax[4], m_pc[4], m_fc[4];
  bit [3:0] m_pp, m_fp, m_ee, m_et, m_er, m_ec;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < 4; ch++) begin
      bit tr, rr, was_open, se, st, sr, sc;
      int e, np, nf, cmn, cmx;
      tr = trig[ch] && !m_pt[ch];
      rr = resp[ch] && !m_pr[ch];
      m_pt[ch] = trig[ch];
      m_pr[ch] = resp[ch];
      if (!C_purstb) begin
        m_pt[ch] = 0; m_pr[ch] = 0; m_open[ch] = 0; m_pc[ch] = 0; m_fc[ch] = 0;
        m_pp[ch] = 0; m_fp[ch] = 0; m_ee[ch] = 0; m_et[ch] = 0; m_er[ch] = 0; m_ec[ch] = 0;
        continue;
      end
      np = 0; nf = 0; se = 0; st = 0; sr = 0; sc = 0;
      was_open = m_open[ch];
      cmn = int'(dly_min[ch*4 +: 4]);
      cmx = int'(dly_max[ch*4 +: 4]);
      if (!ch_en[ch]) begin
        m_open[ch] = 0;
      end else begin
        if (was_open) begin
          e = cyc - m_start[ch];
          if (rr) begin
            if (e < m_wmin[ch]) begin nf++; se = 1; end
            else np++;
            m_open[ch] = 0;
          end else if (e == m_wmax[ch]) begin
            nf++; st = 1; m_open[ch] = 0;
          end
        end
        if (tr) begin
          if (was_open) begin nf++; sr = 1; end
          if (cmn > cmx) begin
            nf++; sc = 1; m_open[ch] = 0;
          end else begin
            m_open[ch] = 1; m_start[ch] = cyc; m_wmin[ch] = cmn; m_wmax[ch] = cmx;
            if (rr && !was_open) begin
              if (cmn > 0) begin nf++; se = 1; end
              else np++;
              m_open[ch] = 0;
            end else if (cmx == 0) begin
              nf++; st = 1; m_open[ch] = 0;
            end
          end
        end
      end
      m_pp[ch] = (np > 0);
      m_fp[ch] = (nf > 0);
      m_pc[ch] = clr ? 0 : m_pc[ch] + np;
      m_fc[ch] = clr ? 0 : m_fc[ch] + nf;
      m_ee[ch] = (clr ? 1'b0 : m_ee[ch]) | se;
      m_et[ch] = (clr ? 1'b0 : m_et[ch]) | st;
      m_er[ch] = (clr ? 1'b0 : m_er[ch]) | sr;
      m_ec[ch] = (clr ? 1'b0 : m_ec[ch]) | sc;
    end
    cyc++;
  endtask

  task automatic check_model();
    logic [3:0]  wb;
    logic [63:0] wpc, wfc;
    logic [7:0]  wpcs, wfcs;
    bit ok;
    for (int ch = 0; ch < 4; ch++) begin
      wb[ch] = m_open[ch];
      wpc[ch*16 +: 16] = 16'(sat(m_pc[ch], 16));
      wfc[ch*16 +: 16] = 16'(sat(m_fc[ch], 16));
      wpcs[ch*2 +: 2]  = 2'(sat(m_pc[ch], 2));
      wfcs[ch*2 +: 2]  = 2'(sat(m_fc[ch], 2));
    end
    ok = (busy === wb) && (pass_pulse === m_pp) && (fail_pulse === m_fp) &&
         (err_early === m_ee) && (err_timeout === m_et) && (err_retrig === m_er) &&
         (err_cfg === m_ec) && (pass_cnt === wpc) && (fail_cnt === wfc) &&
         (busy_s === wb) && (pass_pulse_s === m_pp) && (fail_pulse_s === m_fp) &&
         (err_early_s === m_ee) && (err_timeout_s === m_et) && (err_retrig_s === m_er) &&
         (err_cfg_s === m_ec) && (pass_cnt_s === wpcs) && (fail_cnt_s === wfcs);
    vectors++;
    if (!ok) begin
      miscompares++;
      if (miscompares < 40)
        $display("FAIL model cyc%0d: got b=%h pp=%h fp=%h ee=%h et=%h er=%h ec=%h pc=%h fc=%h pcs=%h fcs=%h bs=%h | want b=%h pp=%h fp=%h ee=%h et=%h er=%h ec=%h pc=%h fc=%h pcs=%h fcs=%h",
                 cyc, busy, pass_pulse, fail_pulse, err_early, err_timeout, err_retrig, err_cfg,
                 pass_cnt, fail_cnt, pass_cnt_s, fail_cnt_s, busy_s,
                 wb, m_pp, m_fp, m_ee, m_et, m_er, m_ec, wpc, wfc, wpcs, wfcs);
    end
  endtask

  task automatic tick(input bit rb, input bit cl, input bit [3:0] en, input bit [3:0] tr, input bit [3:0] rs);
    C_purstb = rb; clr = cl; ch_en = en; trig = tr; resp = rs;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic expect_ch(input string name, input int ch, input bit b, input bit pp, input bit fp,
                           input int pc, input int fc, input bit [3:0] err);
    logic [3:0] gerr;
    gerr = {err_cfg[ch], err_retrig[ch], err_timeout[ch], err_early[ch]};
    vectors++;
    if (busy[ch] !== b || pass_pulse[ch] !== pp || fail_pulse[ch] !== fp ||
        pass_cnt[ch*16 +: 16] !== 16'(pc) || fail_cnt[ch*16 +: 16] !== 16'(fc) || gerr !== err) begin
      miscompares++;
      $display("FAIL %s ch%0d: got b=%b pp=%b fp=%b pc=%0d fc=%0d err=%b want b=%b pp=%b fp=%b pc=%0d fc=%0d err=%b",
               name, ch, busy[ch], pass_pulse[ch], fail_pulse[ch], pass_cnt[ch*16 +: 16],
               fail_cnt[ch*16 +: 16], gerr, b, pp, fp, pc, fc, err);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // err column is {cfg, retrig, timeout, early}
  typedef struct {
    bit       rb;
    bit [3:0] tr;
    bit [3:0] rs;
    int       ch;
    bit       b, pp, fp;
    int       pc, fc;
    bit [3:0] err;
  } vec_t;

  vec_t tbl[24];

  initial begin
    C_purstb = 1'b0; clr = 1'b0; ch_en = 4'h0; trig = 4'h0; resp = 4'h0;
    dly_min = 16'h6032; dly_max = 16'h2352;

    tbl[0]  = '{0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0};
    tbl[1]  = '{1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0};
    tbl[2]  = '{1, 4'h1, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0};
    tbl[3]  = '{1, 4'h1, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0};
    tbl[4]  = '{1, 4'h1, 4'h1, 0, 0, 1, 0, 1, 0, 4'h0};
    tbl[5]  = '{1, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 4'h0};
    tbl[6]  = '{1, 4'h2, 4'h0, 1, 1, 0, 0, 0, 0, 4'h0};
    tbl[7]  = '{1, 4'h2, 4'h2, 1, 0, 0, 1, 0, 1, 4'h1};
    tbl[8]  = '{1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h1};
    tbl[9]  = '{1, 4'h2, 4'h0, 1, 1, 0, 0, 0, 1, 4'h1};
    tbl[10] = '{1, 4'h0, 4'h0, 1, 1, 0, 0, 0, 1, 4'h1};
    tbl[11] = '{1, 4'h0, 4'h0, 1, 1, 0, 0, 0, 1, 4'h1};
    tbl[12] = '{1, 4'h0, 4'h0, 1, 1, 0, 0, 0, 1, 4'h1};
    tbl[13] = '{1, 4'h0, 4'h2, 1, 0, 1, 0, 1, 1, 4'h1};
    tbl[14] = '{1, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 4'h1};
    tbl[15] = '{1, 4'h4, 4'h0, 2, 1, 0, 0, 0, 0, 4'h0};
    tbl[16] = '{1, 4'h0, 4'h0, 2, 1, 0, 0, 0, 0, 4'h0};
    tbl[17] = '{1, 4'h0, 4'h0, 2, 1, 0, 0, 0, 0, 4'h0};
    tbl[18] = '{1, 4'h0, 4'h0, 2, 0, 0, 1, 0, 1, 4'h2};
    tbl[19] = '{1, 4'h0, 4'h0, 2, 0, 0, 0, 0, 1, 4'h2};
    tbl[20] = '{1, 4'h4, 4'h4, 2, 0, 1, 0, 1, 1, 4'h2};
    tbl[21] = '{1, 4'h0, 4'h0, 2, 0, 0, 0, 1, 1, 4'h2};
    tbl[22] = '{1, 4'h8, 4'h0, 3, 0, 0, 1, 0, 1, 4'h8};
    tbl[23] = '{1, 4'h0, 4'h0, 3, 0, 0, 0, 0, 1, 4'h8};

    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      tick(tbl[i].rb, 1'b0, 4'hF, tbl[i].tr, tbl[i].rs);
      expect_ch($sformatf("table%0d", i), tbl[i].ch, tbl[i].b, tbl[i].pp, tbl[i].fp,
                tbl[i].pc, tbl[i].fc, tbl[i].err);
    end

    // Retrigger on ch3 (min 1, max 8), then a pass in the restarted window.
    dly_min = 16'h1032; dly_max = 16'h8352;
    tick(1, 1, 4'hF, 4'h0, 4'h0);
    expect_ch("clr", 3, 0, 0, 0, 0, 0, 4'h0);
    tick(1, 0, 4'hF, 4'h8, 4'h0);
    for (int i = 0; i < 3; i++) tick(1, 0, 4'hF, 4'h0, 4'h0);
    tick(1, 0, 4'hF, 4'h8, 4'h0);
    expect_ch("retrig", 3, 1, 0, 1, 0, 1, 4'h4);
    tick(1, 0, 4'hF, 4'h0, 4'h0);
    expect_ch("retrig_e1", 3, 1, 0, 0, 0, 1, 4'h4);
    tick(1, 0, 4'hF, 4'h0, 4'h8);
    expect_ch("retrig_pass", 3, 0, 1, 0, 1, 1, 4'h4);

    // Five passes on ch2 (min 0): narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 4'hF, 4'h4, 4'h4);
      tick(1, 0, 4'hF, 4'h0, 4'h0);
    end
    check_val("sat_pc_narrow", 64'(pass_cnt_s[5:4]), 64'd3);
    check_val("sat_pc_wide", 64'(pass_cnt[47:32]), 64'd5);
    tick(1, 1, 4'hF, 4'h4, 4'h4);
    check_val("clr_vs_pass_pulse", 64'(pass_pulse[2]), 64'd1);
    check_val("clr_vs_pass_cnt", 64'(pass_cnt[47:32]), 64'd0);
    check_val("clr_vs_pass_cnt_narrow", 64'(pass_cnt_s[5:4]), 64'd0);
    tick(1, 0, 4'hF, 4'h0, 4'h0);

    // Reset in the middle of a ch1 window; ch0 trig held high through reset.
    tick(1, 0, 4'hF, 4'h2, 4'h0);
    tick(1, 0, 4'hF, 4'h0, 4'h0);
    check_val("pre_reset_busy", 64'(busy), 64'h2);
    tick(0, 0, 4'hF, 4'h1, 4'h0);
    check_val("reset_flags", {36'd0, busy, pass_pulse, fail_pulse, err_early, err_timeout, err_retrig, err_cfg}, 64'd0);
    check_val("reset_cnts", pass_cnt | fail_cnt, 64'd0);
    tick(1, 0, 4'hF, 4'h1, 4'h0);
    check_val("rise_at_release", {56'd0, busy, pass_pulse | fail_pulse}, {56'd0, 4'h1, 4'h0});
    for (int i = 0; i < 3; i++) tick(1, 0, 4'hF, 4'h0, 4'h0);

    // All channels concurrently with different windows.
    dly_min = 16'h2103; dly_max = 16'h5426;
    tick(1, 1, 4'hF, 4'h0, 4'h0);
    tick(1, 0, 4'hF, 4'hF, 4'h0);
    check_val("conc_busy", 64'(busy), 64'hF);
    tick(1, 0, 4'hF, 4'h0, 4'h0);
    tick(1, 0, 4'hF, 4'h0, 4'h0);
    check_val("conc_timeout", {56'd0, busy, fail_pulse}, {56'd0, 4'hD, 4'h2});
    tick(1, 0, 4'hF, 4'h0, 4'hF);
    check_val("conc_pass", {56'd0, busy, pass_pulse}, {56'd0, 4'h0, 4'hD});
    check_val("conc_cnts", {pass_cnt, fail_cnt[31:16]}, {16'd1, 16'd1, 16'd0, 16'd1, 16'd1});
    tick(1, 0, 4'hF, 4'h0, 4'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bit [3:0] en, tr, rs;
      int dens;
      if ($urandom_range(0, 49) == 0) begin
        for (int ch = 0; ch < 4; ch++) begin
          int mn, mx;
          mn = $urandom_range(0, 15);
          mx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(mn, 15);
          dly_min[ch*4 +: 4] = 4'(mn);
          dly_max[ch*4 +: 4] = 4'(mx);
        end
      end
      dens = 10 + 15 * ((n / 500) % 3);
      for (int ch = 0; ch < 4; ch++) begin
        en[ch] = ($urandom_range(0, 39) != 0);
        tr[ch] = ($urandom_range(0, 99) < dens);
        rs[ch] = ($urandom_range(0, 99) < dens);
      end
      tick($urandom_range(0, 499) != 0, $urandom_range(0, 199) == 0, en, tr, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tg_edge_delay_monitor.md
Name: tg_edge_delay_monitor

Overview:
- Synthesizable, multi-channel checker for trigger-to-response delay in the TG environment.
- For each channel, a rising edge on the trigger opens a programmable window [dly_min, dly_max] clock cycles long. The response must rise inside that window.
- Each channel counts passes and failures, latches sticky failure causes and emits one-cycle result pulses.
- It sits beside the TG datapath, is readable by the bench or by registers, and replaces exact-delay single-channel checking.

Parameters:
- NCH, 4, number of independent channels
- DW, 4, width of the delay fields and of the elapsed-cycle counter
- CW, 16, width of the pass and fail counters (saturating)

Ports:
- clk  in  1  clock; all logic on posedge
- C_purstb  in  1  synchronous active-low reset
- clr  in  1  synchronous clear of counters and sticky flags; FSMs unaffected
- ch_en  in  NCH  per-channel enable
- trig  in  NCH  per-channel trigger (A)
- resp  in  NCH  per-channel response (B)
- dly_min  in  NCH*DW  per-channel minimum delay; channel i uses [i*DW +: DW]
- dly_max  in  NCH*DW  per-channel maximum delay, same packing
- busy  out  NCH  channel window open
- pass_pulse  out  NCH  one-cycle pulse on a pass
- fail_pulse  out  NCH  one-cycle pulse on a fail
- pass_cnt  out  NCH*CW  per-channel pass count
- fail_cnt  out  NCH*CW  per-channel fail count
- err_early  out  NCH  sticky: response rose before dly_min
- err_timeout  out  NCH  sticky: no response rise by dly_max
- err_retrig  out  NCH  sticky: trigger rose again while the window was open
- err_cfg  out  NCH  sticky: dly_min > dly_max when the trigger rose

Behaviour:
- Reset (C_purstb=0 at posedge):
  - all outputs are 0, all FSMs go to IDLE.
  - the edge-detect history registers for trig and resp are cleared to 0. A signal already high at reset release therefore counts as a rise.
- Edge detect: rise = sig & ~sig_q, where sig_q is registered every cycle.
- Per-channel FSM IDLE/WAIT. `elapsed` is a DW-bit counter. dmin and dmax are copies latched at the trigger rise; later config changes do not affect an open window.
- IDLE, on ch_en & trig-rise:
  - if dly_min > dly_max: set err_cfg, fail_pulse, fail_cnt++; stay in IDLE.
  - else: latch dmin/dmax, set elapsed=0 and evaluate the response in the same cycle (see WAIT rules with e=0).
  - if the window is not resolved, go to WAIT with busy=1 from the next cycle.
- Evaluation at elapsed e, in the cycle resp rises:
  - e < dmin: fail with err_early.
  - dmin ≤ e ≤ dmax: pass.
  - Either way return to IDLE.
- No resp rise and e == dmax: fail with err_timeout, return to IDLE.
- Otherwise: elapsed++. elapsed never wraps because dmax ≤ 2^DW−1.
- Trigger rise in WAIT (ch_en=1):
  - a resp rise in the same cycle is evaluated first against the old window.
  - then err_retrig is set, fail_pulse fires, fail_cnt++, and the window restarts with elapsed=0 and freshly latched delays.
  - if the resp evaluation already produced a result, both results are counted: pass_cnt or fail_cnt +1 for the evaluation, plus fail_cnt +1 for the retrigger. fail_pulse is a single pulse.
- ch_en=0:
  - IDLE ignores triggers.
  - if ch_en drops during WAIT, the channel aborts to IDLE with no pass or fail.
- Pulses and counters are registered: they are visible the cycle after the deciding edge. busy falls in that same cycle.
- Counters saturate at 2^CW−1.
- clr in the same cycle as an increment: clr wins and the counter becomes 0. Sticky flags are cleared the same way, except that a flag set in that same cycle stays 1.
- Reset mid-window aborts silently: no pulse, no count.

Test Plan:
- ch0 min=2,max=2; trig rises at cycle 10, resp rises at 12 → pass_pulse[0] at 13, pass_cnt[0]=1, busy[0] high in cycles 11–12.
- ch1 min=3,max=5; resp rises 1 cycle after trig → err_early[1]=1, fail_cnt[1]=1. Repeat with resp at +4 → pass_cnt[1]=1.
- ch2 min=0,max=3; no resp → fail_pulse at trig+4, err_timeout[2]=1. Repeat with trig and resp rising together → pass via the min=0 path.
- ch3 min=6,max=2 → err_cfg[3]=1 and fail_cnt[3]=1 with no busy. Separately, min=1,max=8 with a second trig at +4 → err_retrig=1, then resp at +2 after the retrigger → pass.
- CW=2: 5 passes → pass_cnt saturates at 3. Pulse clr in the same cycle as a pass → counter 0. Drop C_purstb mid-window → everything 0, no pulse.
- All 4 channels with different windows triggered concurrently → independent counts and no cross-channel interference.
